// File: rtl/usart_pkg.sv
// Shared USART definitions: state encodings for the receiver and transmitter
// and the default bit period.
package usart_pkg;

    localparam int CLKS_PER_BIT_DEF = 16;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_STOP  = 3'd3
    } tx_state_t;

endpackage

// File: rtl/usart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module usart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/usart_rx.sv
// 8N1 serial receiver with mid-bit sampling, frame-error and overrun flags,
// and a level rx_ready / rx_ack handshake toward the consumer.
module usart_rx
    import usart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_dat,
    output logic       rx_ready,
    output logic       is_recv,
    output logic       frame_err,
    output logic       overrun,
    output logic [2:0] dbg_state
);

    // Handshake: rx_ready stays high from byte delivery until rx_ack is seen
    // high on a clock edge; a delivery in that same cycle takes precedence.

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     state, next_state;
    logic          rxs;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          deliver_q;

    logic sample, shift_en, deliver, stop_bad;

    usart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (reset),
        .d   (rxd),
        .q   (rxs)
    );

    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RX_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            RX_IDLE:      if (!rxs) next_state = RX_START;
            RX_START:     if (sample) next_state = rxs ? RX_IDLE : RX_DATA;
            RX_DATA:      if (sample && bit_cnt == 3'd7) next_state = RX_STOP;
            RX_STOP:      if (sample) next_state = rxs ? RX_IDLE : RX_WAIT_IDLE;
            RX_WAIT_IDLE: if (rxs) next_state = RX_IDLE;
            default:      next_state = RX_IDLE;
        endcase
    end

    always_comb begin
        sample   = 1'b0;
        shift_en = 1'b0;
        deliver  = 1'b0;
        stop_bad = 1'b0;
        case (state)
            RX_START: sample = (baud_cnt == HALF_LAST);
            RX_DATA: begin
                sample   = (baud_cnt == FULL_LAST);
                shift_en = sample;
            end
            RX_STOP: begin
                sample   = (baud_cnt == FULL_LAST);
                deliver  = sample && rxs;
                stop_bad = sample && !rxs;
            end
            default: ;
        endcase
    end

    // The detect cycle in IDLE counts toward the half-bit wait, so the start
    // sample lands mid-bit and the nominal latency comes out exact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                RX_IDLE: begin
                    baud_cnt <= rxs ? '0 : CW'(1);
                    bit_cnt  <= '0;
                end
                RX_START, RX_DATA, RX_STOP:
                    baud_cnt <= sample ? '0 : baud_cnt + CW'(1);
                default: baud_cnt <= '0;
            endcase
            if (shift_en) begin
                shift_reg <= {rxs, shift_reg[7:1]};
                bit_cnt   <= bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deliver_q <= 1'b0;
            frame_err <= 1'b0;
            is_recv   <= 1'b0;
            overrun   <= 1'b0;
            rx_ready  <= 1'b0;
            rx_dat    <= '0;
        end else begin
            deliver_q <= deliver;
            frame_err <= stop_bad;
            is_recv   <= (next_state != RX_IDLE);
            overrun   <= deliver_q && rx_ready && !rx_ack;
            if (deliver_q && (!rx_ready || rx_ack)) begin
                rx_dat   <= shift_reg;
                rx_ready <= 1'b1;
            end else if (rx_ack) begin
                rx_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_usart_rx.sv
// Directed bench for usart_rx: driver tasks feed serial frames, a monitor
// checks delivered bytes against an expected queue.
module tb_usart_rx;

    localparam int CPB = 16;
    localparam int LATENCY = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_dat;
    logic       rx_ready;
    logic       is_recv;
    logic       frame_err;
    logic       overrun;
    logic [2:0] dbg_state;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_fall = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    logic [7:0] exp_q[$];

    usart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rx_ack    (rx_ack),
        .rx_dat    (rx_dat),
        .rx_ready  (rx_ready),
        .is_recv   (is_recv),
        .frame_err (frame_err),
        .overrun   (overrun),
        .dbg_state (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    // driver: one 8N1 frame; stop_val=0 forces a bad stop bit and leaves rxd low
    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        @(posedge clk);
        #1 rxd = 1'b0;
        last_fall = cyc;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rxd = b[i];
            repeat (CPB) @(posedge clk);
        end
        #1 rxd = stop_val;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic pulse_ack();
        @(posedge clk);
        #1 rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
    endtask

    // monitor / scoreboard: a delivery is ready rising or rx_dat changing while ready
    logic       prev_ready = 1'b0;
    logic [7:0] prev_dat = 8'h00;
    always @(negedge clk) begin
        if (reset) begin
            prev_ready = 1'b0;
            prev_dat   = 8'h00;
        end else begin
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (rx_ready && (!prev_ready || rx_dat != prev_dat)) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_byte: got=0x%0h want=none", rx_dat);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rx_dat !== e) begin
                        bad++;
                        $display("FAIL byte: got=0x%0h want=0x%0h", rx_dat, e);
                    end
                end
                total++;
                if (cyc - last_fall < LATENCY - 1 || cyc - last_fall > LATENCY + 1) begin
                    bad++;
                    $display("FAIL latency: got=%0d want=%0d", cyc - last_fall, LATENCY);
                end
            end
            prev_ready = rx_ready;
            prev_dat   = rx_dat;
        end
    end

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rx_dat", rx_dat, 0);
        check("reset_rx_ready", rx_ready, 0);
        check("reset_is_recv", is_recv, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        check("reset_state", dbg_state, 0);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);

        // single byte
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("a5_dat", rx_dat, 32'hA5);
        check("a5_ready", rx_ready, 1);
        check("a5_ferr", ferr_cnt, 0);
        pulse_ack();
        @(negedge clk);
        check("a5_ack_clears", rx_ready, 0);

        // back-to-back without ack -> overrun, first byte kept
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        send_byte(8'hC3, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("ovr_dat", rx_dat, 32'h3C);
        check("ovr_ready", rx_ready, 1);
        check("ovr_count", ovr_cnt, 1);
        pulse_ack();
        @(negedge clk);
        check("ovr_ack_clears", rx_ready, 0);

        // 4-cycle glitch on idle line
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("glitch_seen", is_recv, 1);
        rxd = 1'b1;
        for (int i = 0; i < 12 && is_recv; i++) @(negedge clk);
        check("glitch_is_recv", is_recv, 0);
        check("glitch_state", dbg_state, 0);
        check("glitch_ready", rx_ready, 0);

        // bad stop bit followed by break
        send_byte(8'h55, 1'b0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("break_state", dbg_state, 4);
        check("break_is_recv", is_recv, 1);
        check("ferr_ready", rx_ready, 0);
        check("ferr_count", ferr_cnt, 1);
        #1 rxd = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("break_end_state", dbg_state, 0);
        check("break_end_is_recv", is_recv, 0);

        // reset during data bit 4 of 0xFF
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (4 * CPB + CPB / 2) @(posedge clk);
        #1 check("mid_is_recv", is_recv, 1);
        check("mid_state", dbg_state, 2);
        reset = 1'b1;
        #1;
        check("abort_rx_dat", rx_dat, 0);
        check("abort_is_recv", is_recv, 0);
        check("abort_state", dbg_state, 0);
        check("abort_ready", rx_ready, 0);
        repeat (CPB) @(posedge clk);
        #1 reset = 1'b0;
        repeat (CPB) @(posedge clk);
        check("abort_no_ferr", ferr_cnt, 1);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("after_reset_dat", rx_dat, 32'h81);
        check("after_reset_ready", rx_ready, 1);

        // ack in the delivery cycle of a new byte
        exp_q.push_back(8'h5A);
        fork
            send_byte(8'h5A, 1'b1);
            begin
                @(negedge rxd);
                repeat (LATENCY - 1) @(posedge clk);
                #1 rx_ack = 1'b1;
                @(posedge clk);
                #1 rx_ack = 1'b0;
            end
        join
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("ackdel_dat", rx_dat, 32'h5A);
        check("ackdel_ready", rx_ready, 1);
        check("ackdel_no_ovr", ovr_cnt, 1);

        check("exp_q_empty", exp_q.size(), 0);
        check("final_ferr", ferr_cnt, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/usart_rx.md
USART_RX -- requirements
Module: usart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; legal range 4..1024.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rxd  input  1  asynchronous serial line; idles high.
REQ-005 rx_dat  output  8  last received byte.
REQ-006 rx_ready  output  1  level; high while rx_dat holds an unacknowledged byte.
REQ-007 rx_ack  input  1  consumer acknowledge; clears rx_ready.
REQ-008 is_recv  output  1  high while a frame is in progress (any state other than IDLE).
REQ-009 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-010 overrun  output  1  one-cycle pulse when a good byte completes while rx_ready is high.

Function
REQ-011 Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-012 rxd passes through a 2-flop synchronizer, reset value 1; all decisions use the synchronized value rxs.
REQ-013 States: IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-014 IDLE: rxs==0 -> START and clear the bit counter; otherwise stay.
REQ-015 START: after CLKS_PER_BIT/2 cycles (integer division), sample rxs. 0 -> DATA. 1 -> IDLE (glitch rejected; no outputs change).
REQ-016 DATA: sample rxs every CLKS_PER_BIT cycles and shift it into bit position 7 of the shift register, shifting right. After the 8th sample -> STOP.
REQ-017 STOP: sample after CLKS_PER_BIT cycles. 1 -> IDLE and deliver the byte. 0 -> assert frame_err, discard the byte, and go to WAIT_IDLE.
REQ-018 WAIT_IDLE: stay until rxs==1, then -> IDLE. This absorbs break conditions without false start detection.
REQ-019 Delivery when rx_ready==0: rx_dat is loaded and rx_ready is set in the cycle after the stop sample.
REQ-020 Delivery when rx_ready==1: the overrun pulse fires, the new byte is dropped, and rx_dat and rx_ready are unchanged.
REQ-021 rx_ack==1 clears rx_ready on the next edge. rx_ack while rx_ready==0 is ignored.
REQ-022 If rx_ack and a delivery fall in the same cycle, delivery wins: rx_dat is loaded, rx_ready stays 1, and there is no overrun.
REQ-023 The baud counter width is $clog2(CLKS_PER_BIT) and it reloads at each sample. The bit counter is 3 bits; wrap from 7 to 0 marks the end of DATA.
REQ-024 Nominal latency from a falling edge on rxd to rx_ready: 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles.
REQ-025 rx_ready, rx_dat, is_recv, frame_err and overrun are all registered outputs.

Reset
REQ-026 On reset: state=IDLE; synchronizer=1; counters=0; rx_dat=0; rx_ready=0; is_recv=0; frame_err=0; overrun=0.
REQ-027 Reset asserted mid-frame aborts the frame immediately. No partial byte is ever delivered, and no error pulse is raised.
REQ-028 After reset deassertion, reception resumes at the next falling edge of rxs.

Structure
REQ-029 The state encoding constants (3-bit) and the default CLKS_PER_BIT belong in the shared package usart_pkg, together with the tx state constants.
REQ-030 The 2-flop synchronizer is a sub-module, usart_sync, with parameter RESET_VAL=1.
REQ-031 The estimated RTL size is 150-250 lines, excluding the package.

Verification
REQ-032 Bench parameter: CLKS_PER_BIT=16. Send 0xA5 -> rx_dat=0xA5, rx_ready rises 155±1 cycles after the rxd fall, frame_err=0.
REQ-033 Send 0x3C then 0xC3 back-to-back with no rx_ack -> rx_dat=0x3C, one overrun pulse at the second stop, rx_ready stays 1.
REQ-034 Drive a 4-cycle low glitch on idle rxd -> state returns to IDLE, is_recv drops within 12 cycles, rx_ready=0.
REQ-035 Send 0x55 with the stop bit forced 0, holding rxd low for 40 more cycles -> one frame_err pulse, rx_ready=0, no new start until rxd returns high.
REQ-036 Assert reset at data bit 4 of 0xFF -> all outputs 0 at once. The following 0x81 is received correctly as 0x81.
REQ-037 Pulse rx_ack in the same cycle a second byte is delivered -> rx_dat holds the new byte, rx_ready=1, no overrun.
